// File: rtl/sync_bus_ctrl.sv
// sync_bus_ctrl: destination-domain sequencer for the enable-gated bus synchroniser.
// A 4-phase req is synchronised, allowed to settle, then a single-cycle load_en
// captures the bus word. data_valid and ack follow, and ack holds until req drops.
// Optional error logic is built only when SYNC_BUS_CTRL_ERR_EN is defined. It
// provides a one-cycle err pulse and a saturating err_count on settle aborts.
module sync_bus_ctrl #(
  parameter int NUM_STAGES    = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_async,
  output logic                 load_en,
  output logic                 data_valid,
  output logic                 ack,
  output logic                 busy,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOAD,
    ACK
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  req_s;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  load_q, dv_q, ack_q, busy_q;

  // Synchroniser chain: the only consumer of req_async.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[NUM_STAGES-2:0], req_async};
  end

  assign req_s = sync_q[NUM_STAGES-1];

  // State and settle counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic for the 4-phase sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          cnt_d   = '0;
          state_d = (SETTLE_CYCLES == 0) ? LOAD : SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (!req_s)                    state_d = IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = LOAD;
      end
      LOAD:    state_d = ACK;
      ACK:     if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output flags are registered from next state, so each output comes
  // straight from a flop and never carries decode glitches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      load_q <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      dv_q   <= 1'b0;
    end else begin
      load_q <= (state_d == LOAD);
      ack_q  <= (state_d == ACK);
      busy_q <= (state_d != IDLE);
      dv_q   <= (state_q == LOAD);
    end
  end

  assign load_en    = load_q;
  assign data_valid = dv_q;
  assign ack        = ack_q;
  assign busy       = busy_q;

`ifdef SYNC_BUS_CTRL_ERR_EN
  logic                 err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Settle abort: pulse err and bump the saturating count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= (state_q == SETTLE) && !req_s;
      if ((state_q == SETTLE) && !req_s && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err       = err_q;
  assign err_count = err_cnt_q;
`else
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sync_bus_ctrl.sv
// Bench for sync_bus_ctrl. Three instances cover the parameter sets
// (2,1), (2,3) and (3,0). A timeline model checks every cycle, and
// directed sequences pin the documented edge latencies.
module tb_sync_bus_ctrl;

`ifdef SYNC_BUS_CTRL_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      req = '0;
  logic [2:0]      load_en, data_valid, ack, busy, err;
  logic [2:0][7:0] ecnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_bus_ctrl #(.NUM_STAGES(2), .SETTLE_CYCLES(1), .ERR_CNT_W(8)) u0 (
    .CLK(clk), .RST(rst), .req_async(req[0]), .load_en(load_en[0]),
    .data_valid(data_valid[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]),
    .err_count(ecnt[0]));
  sync_bus_ctrl #(.NUM_STAGES(2), .SETTLE_CYCLES(3), .ERR_CNT_W(8)) u1 (
    .CLK(clk), .RST(rst), .req_async(req[1]), .load_en(load_en[1]),
    .data_valid(data_valid[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]),
    .err_count(ecnt[1]));
  sync_bus_ctrl #(.NUM_STAGES(3), .SETTLE_CYCLES(0), .ERR_CNT_W(8)) u2 (
    .CLK(clk), .RST(rst), .req_async(req[2]), .load_en(load_en[2]),
    .data_valid(data_valid[2]), .ack(ack[2]), .busy(busy[2]), .err(err[2]),
    .err_count(ecnt[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ns_of(int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int sc_of(int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  // Timeline model: a transfer starts at the edge t0 where the synchronised
  // req is seen high while idle. Later outputs follow from the phase e - t0.
  int         edge_n = 0;
  int         t0    [3];
  logic [7:0] hist  [3];
  logic       m_load[3], m_dv[3], m_ack[3], m_busy[3], m_err[3];
  int         m_cnt [3];
  int         nload [3];
  int         nack  [3];
  logic [2:0] req_smp = '0;
  logic       rst_smp = 1'b0;

  always @(posedge clk) begin
    req_smp <= req;
    rst_smp <= rst;
  end

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      t0[i] = -1; hist[i] = '0; m_cnt[i] = 0;
      m_load[i] = 0; m_dv[i] = 0; m_ack[i] = 0; m_busy[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      int s, p, ph;
      logic rs;
      s  = sc_of(i);
      rs = hist[i][ns_of(i)-1];
      m_err[i] = 1'b0;
      if (t0[i] < 0) begin
        if (rs) t0[i] = edge_n;
      end else begin
        p = edge_n - 1 - t0[i];
        if (!rs && p < s) begin
          t0[i] = -1;
          m_err[i] = 1'b1;
          if (m_cnt[i] < 255) m_cnt[i]++;
        end else if (!rs && p > s) begin
          t0[i] = -1;
        end
      end
      hist[i] = {hist[i][6:0], req_smp[i]};
      if (t0[i] < 0) begin
        m_load[i] = 0; m_dv[i] = 0; m_ack[i] = 0; m_busy[i] = 0;
      end else begin
        ph = edge_n - t0[i];
        m_load[i] = (ph == s);
        m_dv[i]   = (ph == s + 1);
        m_ack[i]  = (ph > s);
        m_busy[i] = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) begin nload[i] = 0; nack[i] = 0; end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst || rst_smp) model_reset();
    else model_edge();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.load_en", i), load_en[i], m_load[i]);
      chk($sformatf("u%0d.data_valid", i), data_valid[i], m_dv[i]);
      chk($sformatf("u%0d.ack", i), ack[i], m_ack[i]);
      chk($sformatf("u%0d.busy", i), busy[i], m_busy[i]);
      chk($sformatf("u%0d.err", i), err[i], ERR_ON ? m_err[i] : 1'b0);
      chk($sformatf("u%0d.err_count", i), ecnt[i], ERR_ON ? m_cnt[i] : 0);
      if (load_en[i]) nload[i]++;
      if (ack[i])     nack[i]++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int base_l, base_a;

  initial begin
    #1 rst = 1'b1;
    step(2);
    #1;
    chk("reset_outputs", {load_en[0], data_valid[0], ack[0], busy[0], err[0]}, 0);

    // Directed: basic transfer on (2,1); edge 0 is here.
    rst = 1'b0; req[0] = 1'b1; base_l = nload[0];
    step(2); chk("t1_busy_e2", busy[0], 0);
    step(1); chk("t1_busy_e3", busy[0], 1); chk("t1_load_e3", load_en[0], 0);
    step(1); chk("t1_load_e4", load_en[0], 1); chk("t1_ack_e4", ack[0], 0);
    step(1); chk("t1_load_e5", load_en[0], 0); chk("t1_ack_e5", ack[0], 1);
             chk("t1_dv_e5", data_valid[0], 1);
    step(1); chk("t1_dv_e6", data_valid[0], 0); chk("t1_ack_e6", ack[0], 1);
    step(4); req[0] = 1'b0;
    step(2); chk("t2_ack_e12", ack[0], 1);
    step(1); chk("t2_ack_e13", ack[0], 0); chk("t2_busy_e13", busy[0], 0);
    chk("t2_one_load", nload[0] - base_l, 1);

    // Directed: SETTLE_CYCLES=0 with three stages on u2.
    req[2] = 1'b1;
    step(3); chk("t4_load_e3", load_en[2], 0); chk("t4_busy_e3", busy[2], 0);
    step(1); chk("t4_load_e4", load_en[2], 1);
    step(1); chk("t4_ack_e5", ack[2], 1); chk("t4_dv_e5", data_valid[2], 1);
    req[2] = 1'b0;
    step(6); chk("t4_idle", busy[2], 0);

    // Directed: reset while in ACK with req held high.
    req[0] = 1'b1;
    for (int k = 0; k < 20 && !ack[0]; k++) step(1);
    chk("t5_ack_reached", ack[0], 1);
    rst = 1'b1;
    #1;
    chk("t5_async_clear", {load_en[0], data_valid[0], ack[0], busy[0]}, 0);
    step(1);
    rst = 1'b0; base_l = nload[0];
    step(3); chk("t5_load_e3", load_en[0], 0); chk("t5_busy_e3", busy[0], 1);
    step(1); chk("t5_load_e4", load_en[0], 1);
    step(1); chk("t5_ack_e5", ack[0], 1);
    req[0] = 1'b0;
    step(6); chk("t5_idle", busy[0], 0); chk("t5_one_load", nload[0] - base_l, 1);

    // Directed: abort in SETTLE on (2,3).
    base_l = nload[1]; base_a = nack[1];
    req[1] = 1'b1;
    step(3); req[1] = 1'b0;
    step(3); chk("t3_err_e6", err[1], ERR_ON ? 1 : 0);
             chk("t3_cnt_e6", ecnt[1], ERR_ON ? 1 : 0);
             chk("t3_busy_e6", busy[1], 0);
    step(1); chk("t3_err_e7", err[1], 0);
    chk("t3_no_load", nload[1] - base_l, 0);
    chk("t3_no_ack", nack[1] - base_a, 0);

    // Directed: 300 further aborts saturate the count.
    for (int k = 0; k < 300; k++) begin
      req[1] = 1'b1; step(3);
      req[1] = 1'b0; step(4);
    end
    chk("t6_saturated", ecnt[1], ERR_ON ? 255 : 0);
    req[1] = 1'b1; step(3);
    req[1] = 1'b0; step(4);
    chk("t6_holds", ecnt[1], ERR_ON ? 255 : 0);
    chk("t6_no_load", nload[1] - base_l, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
